// File: rtl/cs_complete_buffer_if.sv
// Result/completion bundle for cs_complete_buffer.
// master: the side that owns the functional units and consumes the ROB/CDB outputs.
// slave:  the complete-stage buffer itself.
interface cs_complete_buffer_if #(
   parameter int NUM_FU             = 4,
   parameter int DEPTH              = 8,
   parameter int PREG_W             = 6,
   parameter int SYS_ROB_ADDR_WIDTH = 6,
   parameter int SYS_XLEN           = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_FU-1:0]                         fu_valid;
   logic                                      fu_ready;
   logic [NUM_FU-1:0][SYS_ROB_ADDR_WIDTH-1:0] fu_rob_idx;
   logic [NUM_FU-1:0][PREG_W-1:0]             fu_tag;
   logic [NUM_FU-1:0][SYS_XLEN-1:0]           fu_value;
   logic [NUM_FU-1:0][SYS_XLEN-1:0]           fu_pc;
   logic [NUM_FU-1:0]                         fu_is_br;
   logic [NUM_FU-1:0]                         fu_br_taken;
   logic [NUM_FU-1:0][SYS_XLEN-1:0]           fu_br_target;
   logic [NUM_FU-1:0]                         fu_pred_taken;
   logic [NUM_FU-1:0][SYS_XLEN-1:0]           fu_pred_target;
   logic                                      fch_rec_enable;

   logic [2:0]                                cs_retire_valid;
   logic [2:0][SYS_ROB_ADDR_WIDTH-1:0]        cs_retire_idx;
   logic [2:0]                                rb_recover_valid;
   logic [2:0][SYS_XLEN-1:0]                  cs_retire_pc;
   logic [2:0]                                cdb_valid;
   logic [2:0][PREG_W-1:0]                    cdb_tag;
   logic [2:0][SYS_XLEN-1:0]                  cdb_value;
   logic [CNT_W-1:0]                          cs_buf_count;

   modport master (
      output fu_valid, fu_rob_idx, fu_tag, fu_value, fu_pc, fu_is_br,
             fu_br_taken, fu_br_target, fu_pred_taken, fu_pred_target, fch_rec_enable,
      input  fu_ready, cs_retire_valid, cs_retire_idx, rb_recover_valid, cs_retire_pc,
             cdb_valid, cdb_tag, cdb_value, cs_buf_count
   );

   modport slave (
      input  fu_valid, fu_rob_idx, fu_tag, fu_value, fu_pc, fu_is_br,
             fu_br_taken, fu_br_target, fu_pred_taken, fu_pred_target, fch_rec_enable,
      output fu_ready, cs_retire_valid, cs_retire_idx, rb_recover_valid, cs_retire_pc,
             cdb_valid, cdb_tag, cdb_value, cs_buf_count
   );
endinterface

// File: rtl/cs_complete_buffer.sv
// Complete-stage buffer: collects finished FU results into a circular FIFO
// and drains up to three per cycle to the ROB completion ports and the CDB.
// Branch outcomes are resolved on the way in so the ROB sees a ready-made
// mispredict flag and redirect PC.
// Optional feature macro: CS_TARGET_CHECK_EN -- when defined, a taken branch
// that was predicted taken but to a different target is also a mispredict.
module cs_complete_buffer #(
   parameter int NUM_FU             = 4,
   parameter int DEPTH              = 8,
   parameter int PREG_W             = 6,
   parameter int SYS_ROB_ADDR_WIDTH = 6,
   parameter int SYS_XLEN           = 32
) (
   input logic                clk,
   input logic                rst_n,
   cs_complete_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [PTR_W-1:0] head, tail;
   logic [CW-1:0]    count;

   logic [SYS_ROB_ADDR_WIDTH-1:0] mem_idx   [DEPTH];
   logic [PREG_W-1:0]             mem_tag   [DEPTH];
   logic [SYS_XLEN-1:0]           mem_value [DEPTH];
   logic                          mem_mis   [DEPTH];
   logic [SYS_XLEN-1:0]           mem_pc    [DEPTH];

   logic [CW-1:0]      drain_cnt;
   logic [CW:0]        space_avail;
   logic               ready_int;
   logic [CW-1:0]      acc_cnt;
   logic [NUM_FU-1:0]  wr_en;
   logic [PTR_W-1:0]   wr_ptr [NUM_FU];
   logic [NUM_FU-1:0]  res_mis;
   logic [SYS_XLEN-1:0] res_pc [NUM_FU];
   logic [PTR_W-1:0]   rd_ptr;

   // Ready depends only on registered occupancy: free slots plus what drains this cycle.
   always_comb begin
      drain_cnt   = (count >= CW'(3)) ? CW'(3) : count;
      space_avail = (CW+1)'(DEPTH) - {1'b0, count} + {1'b0, drain_cnt};
      ready_int   = space_avail >= (CW+1)'(NUM_FU);
      bus.fu_ready = ready_int;
   end

   // Pack accepted results contiguously at the tail, lowest FU index first.
   always_comb begin
      acc_cnt = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         wr_en[i]  = bus.fu_valid[i] && ready_int;
         wr_ptr[i] = tail + acc_cnt[PTR_W-1:0];
         if (wr_en[i]) acc_cnt = acc_cnt + CW'(1);
      end
   end

`ifdef CS_TARGET_CHECK_EN
   // Resolve each incoming branch, including wrong-target on a correctly predicted taken branch.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         res_mis[i] = bus.fu_is_br[i] &&
                      ((bus.fu_br_taken[i] != bus.fu_pred_taken[i]) ||
                       (bus.fu_br_taken[i] && bus.fu_pred_taken[i] &&
                        (bus.fu_br_target[i] != bus.fu_pred_target[i])));
         res_pc[i]  = !bus.fu_is_br[i] ? '0 :
                      bus.fu_br_taken[i] ? bus.fu_br_target[i] : bus.fu_pc[i] + SYS_XLEN'(4);
      end
   end
`else
   // The predicted target is not consulted in this build.
   logic unused_pred_target;
   assign unused_pred_target = ^bus.fu_pred_target;

   // Resolve each incoming branch on direction only.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         res_mis[i] = bus.fu_is_br[i] && (bus.fu_br_taken[i] != bus.fu_pred_taken[i]);
         res_pc[i]  = !bus.fu_is_br[i] ? '0 :
                      bus.fu_br_taken[i] ? bus.fu_br_target[i] : bus.fu_pc[i] + SYS_XLEN'(4);
      end
   end
`endif

   // Entry storage; stale contents are harmless because outputs are gated by count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (wr_en[i] && !bus.fch_rec_enable) begin
            mem_idx[wr_ptr[i]]   <= bus.fu_rob_idx[i];
            mem_tag[wr_ptr[i]]   <= bus.fu_tag[i];
            mem_value[wr_ptr[i]] <= bus.fu_value[i];
            mem_mis[wr_ptr[i]]   <= res_mis[i];
            mem_pc[wr_ptr[i]]    <= res_pc[i];
         end
      end
   end

   // Pointer and occupancy bookkeeping; a flush discards everything including this cycle's pushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.fch_rec_enable) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + drain_cnt[PTR_W-1:0];
         tail  <= tail + acc_cnt[PTR_W-1:0];
         count <= count - drain_cnt + acc_cnt;
      end
   end

   // Present the three oldest entries; empty slots drive zeros on every field.
   always_comb begin
      rd_ptr = '0;
      for (int s = 0; s < 3; s++) begin
         rd_ptr                  = head + PTR_W'(s);
         bus.cs_retire_valid[s]  = 1'b0;
         bus.cs_retire_idx[s]    = '0;
         bus.rb_recover_valid[s] = 1'b0;
         bus.cs_retire_pc[s]     = '0;
         bus.cdb_valid[s]        = 1'b0;
         bus.cdb_tag[s]          = '0;
         bus.cdb_value[s]        = '0;
         if (count > CW'(s)) begin
            bus.cs_retire_valid[s]  = 1'b1;
            bus.cs_retire_idx[s]    = mem_idx[rd_ptr];
            bus.rb_recover_valid[s] = mem_mis[rd_ptr];
            bus.cs_retire_pc[s]     = mem_pc[rd_ptr];
            bus.cdb_valid[s]        = 1'b1;
            bus.cdb_tag[s]          = mem_tag[rd_ptr];
            bus.cdb_value[s]        = mem_value[rd_ptr];
         end
      end
      bus.cs_buf_count = count;
   end
endmodule

// File: tb/tb_cs_complete_buffer.sv
// Directed testbench for cs_complete_buffer: reset, single and multiple results,
// branch resolution, sustained backpressure, flush and asynchronous reset.
module tb_cs_complete_buffer;
   localparam int NUM_FU = 4;
   localparam int DEPTH  = 8;
   localparam int PREG_W = 6;
   localparam int ROB_W  = 6;
   localparam int XLEN   = 32;

`ifdef CS_TARGET_CHECK_EN
   localparam logic TGT_MIS_EXP = 1'b1;
`else
   localparam logic TGT_MIS_EXP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cs_complete_buffer_if #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .PREG_W(PREG_W),
                           .SYS_ROB_ADDR_WIDTH(ROB_W), .SYS_XLEN(XLEN)) bus ();

   cs_complete_buffer #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .PREG_W(PREG_W),
                        .SYS_ROB_ADDR_WIDTH(ROB_W), .SYS_XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Count one comparison and report it if the DUT disagrees with the bench.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Offer one result on an FU port.
   task automatic applyStimulus(input int port, input int idx, input int tag, input logic [XLEN-1:0] value,
                                input logic [XLEN-1:0] pc, input logic is_br, input logic br_taken,
                                input logic [XLEN-1:0] br_target, input logic pred_taken,
                                input logic [XLEN-1:0] pred_target);
      bus.fu_valid[port]       = 1'b1;
      bus.fu_rob_idx[port]     = ROB_W'(idx);
      bus.fu_tag[port]         = PREG_W'(tag);
      bus.fu_value[port]       = value;
      bus.fu_pc[port]          = pc;
      bus.fu_is_br[port]       = is_br;
      bus.fu_br_taken[port]    = br_taken;
      bus.fu_br_target[port]   = br_target;
      bus.fu_pred_taken[port]  = pred_taken;
      bus.fu_pred_target[port] = pred_target;
   endtask

   // Withdraw all FU results and the flush request.
   task automatic clearStimulus();
      bus.fu_valid       = '0;
      bus.fu_rob_idx     = '0;
      bus.fu_tag         = '0;
      bus.fu_value       = '0;
      bus.fu_pc          = '0;
      bus.fu_is_br       = '0;
      bus.fu_br_taken    = '0;
      bus.fu_br_target   = '0;
      bus.fu_pred_taken  = '0;
      bus.fu_pred_target = '0;
      bus.fch_rec_enable = 1'b0;
   endtask

   int   q[$];
   int   next_id;
   int   n_drain;
   logic exp_ready;

   initial begin
      clearStimulus();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      checkOutput("rst_ready", 64'(bus.fu_ready), 64'd1);
      checkOutput("rst_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("rst_retire_valid", 64'(bus.cs_retire_valid), 64'd0);
      checkOutput("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);

      // Single non-branch result
      applyStimulus(0, 5, 7, 32'h1234, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      clearStimulus();
      checkOutput("one_valid", 64'(bus.cs_retire_valid), 64'b001);
      checkOutput("one_idx", 64'(bus.cs_retire_idx[0]), 64'd5);
      checkOutput("one_tag", 64'(bus.cdb_tag[0]), 64'd7);
      checkOutput("one_value", 64'(bus.cdb_value[0]), 64'h1234);
      checkOutput("one_cdb_valid", 64'(bus.cdb_valid), 64'b001);
      checkOutput("one_nonbr_pc", 64'(bus.cs_retire_pc[0]), 64'd0);
      checkOutput("one_nonbr_rec", 64'(bus.rb_recover_valid), 64'd0);
      @(negedge clk);
      checkOutput("one_after_valid", 64'(bus.cs_retire_valid), 64'd0);
      checkOutput("one_after_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("one_after_value", 64'(bus.cdb_value[0]), 64'd0);

      // Four simultaneous results
      for (int i = 0; i < 4; i++)
         applyStimulus(i, i + 1, 11 + i, 32'h200 + i, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      clearStimulus();
      checkOutput("four_valid", 64'(bus.cs_retire_valid), 64'b111);
      checkOutput("four_idx0", 64'(bus.cs_retire_idx[0]), 64'd1);
      checkOutput("four_idx1", 64'(bus.cs_retire_idx[1]), 64'd2);
      checkOutput("four_idx2", 64'(bus.cs_retire_idx[2]), 64'd3);
      checkOutput("four_tag2", 64'(bus.cdb_tag[2]), 64'd13);
      checkOutput("four_count", 64'(bus.cs_buf_count), 64'd4);
      @(negedge clk);
      checkOutput("four_late_valid", 64'(bus.cs_retire_valid), 64'b001);
      checkOutput("four_late_idx", 64'(bus.cs_retire_idx[0]), 64'd4);
      checkOutput("four_late_tag", 64'(bus.cdb_tag[0]), 64'd14);
      checkOutput("four_late_count", 64'(bus.cs_buf_count), 64'd1);
      @(negedge clk);
      checkOutput("four_empty", 64'(bus.cs_buf_count), 64'd0);

      // Branch resolution: direction wrong both ways, target wrong, fully correct
      applyStimulus(0, 20, 1, 32'h0, 32'h4000, 1'b1, 1'b1, 32'h5000, 1'b0, 32'h0);
      applyStimulus(1, 21, 2, 32'h0, 32'h4000, 1'b1, 1'b0, 32'h5000, 1'b1, 32'h5000);
      applyStimulus(2, 22, 3, 32'h0, 32'h4000, 1'b1, 1'b1, 32'h5000, 1'b1, 32'h6000);
      applyStimulus(3, 23, 4, 32'h0, 32'h4000, 1'b1, 1'b1, 32'h5000, 1'b1, 32'h5000);
      @(negedge clk);
      clearStimulus();
      checkOutput("br_nt_taken_rec", 64'(bus.rb_recover_valid[0]), 64'd1);
      checkOutput("br_nt_taken_pc", 64'(bus.cs_retire_pc[0]), 64'h5000);
      checkOutput("br_t_nt_rec", 64'(bus.rb_recover_valid[1]), 64'd1);
      checkOutput("br_t_nt_pc", 64'(bus.cs_retire_pc[1]), 64'h4004);
      checkOutput("br_tgt_rec", 64'(bus.rb_recover_valid[2]), 64'(TGT_MIS_EXP));
      checkOutput("br_tgt_pc", 64'(bus.cs_retire_pc[2]), 64'h5000);
      @(negedge clk);
      checkOutput("br_ok_idx", 64'(bus.cs_retire_idx[0]), 64'd23);
      checkOutput("br_ok_rec", 64'(bus.rb_recover_valid[0]), 64'd0);
      checkOutput("br_ok_pc", 64'(bus.cs_retire_pc[0]), 64'h5000);
      @(negedge clk);

      // Sustained backpressure: all FUs always valid, holding until accepted
      q.delete();
      next_id = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         n_drain   = (q.size() < 3) ? q.size() : 3;
         exp_ready = (DEPTH - q.size() + n_drain) >= NUM_FU;
         checkOutput("bp_ready", 64'(bus.fu_ready), 64'(exp_ready));
         for (int i = 0; i < NUM_FU; i++)
            applyStimulus(i, next_id + i, next_id + i, 32'h100 + next_id + i, 32'h0,
                          1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         @(posedge clk);
         for (int k = 0; k < n_drain; k++) void'(q.pop_front());
         if (exp_ready) begin
            for (int i = 0; i < NUM_FU; i++) q.push_back(next_id + i);
            next_id += NUM_FU;
         end
         @(negedge clk);
         checkOutput("bp_count", 64'(bus.cs_buf_count), 64'(q.size()));
         checkOutput("bp_le_depth", 64'(bus.cs_buf_count <= DEPTH), 64'd1);
         for (int s = 0; s < 3; s++) begin
            checkOutput("bp_slot_valid", 64'(bus.cs_retire_valid[s]), 64'(s < q.size()));
            if (s < q.size()) begin
               checkOutput("bp_slot_idx", 64'(bus.cs_retire_idx[s]), 64'(q[s] & 63));
               checkOutput("bp_slot_value", 64'(bus.cdb_value[s]), 64'(32'h100 + q[s]));
            end
         end
      end
      clearStimulus();
      for (int cyc = 0; cyc < 4; cyc++) begin
         n_drain = (q.size() < 3) ? q.size() : 3;
         @(posedge clk);
         for (int k = 0; k < n_drain; k++) void'(q.pop_front());
         @(negedge clk);
         checkOutput("bp_drain_count", 64'(bus.cs_buf_count), 64'(q.size()));
         if (q.size() > 0)
            checkOutput("bp_drain_idx", 64'(bus.cs_retire_idx[0]), 64'(q[0] & 63));
      end
      checkOutput("bp_empty", 64'(bus.cs_buf_count), 64'd0);

      // Flush with count=5 and three new results offered
      for (int i = 0; i < 4; i++)
         applyStimulus(i, 40 + i, i, 32'h400 + i, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         applyStimulus(i, 44 + i, i, 32'h440 + i, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      clearStimulus();
      checkOutput("fl_pre_count", 64'(bus.cs_buf_count), 64'd5);
      for (int i = 0; i < 3; i++)
         applyStimulus(i, 48 + i, i, 32'h480 + i, 32'h4000, 1'b1, 1'b1, 32'h5000, 1'b0, 32'h0);
      bus.fch_rec_enable = 1'b1;
      @(negedge clk);
      clearStimulus();
      checkOutput("fl_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("fl_retire_valid", 64'(bus.cs_retire_valid), 64'd0);
      checkOutput("fl_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      checkOutput("fl_recover", 64'(bus.rb_recover_valid), 64'd0);
      checkOutput("fl_value", 64'(bus.cdb_value[0]), 64'd0);
      checkOutput("fl_ready", 64'(bus.fu_ready), 64'd1);
      @(negedge clk);
      checkOutput("fl_later_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("fl_later_valid", 64'(bus.cs_retire_valid), 64'd0);

      // Asynchronous reset mid-operation
      applyStimulus(0, 60, 1, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1, 61, 2, 32'h601, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      checkOutput("ar_pre_count", 64'(bus.cs_buf_count), 64'd2);
      rst_n = 1'b0;
      #1;
      checkOutput("ar_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("ar_valid", 64'(bus.cs_retire_valid), 64'd0);
      checkOutput("ar_ready", 64'(bus.fu_ready), 64'd1);
      @(negedge clk);
      clearStimulus();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ar_after_count", 64'(bus.cs_buf_count), 64'd0);
      checkOutput("ar_after_valid", 64'(bus.cdb_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
